xpb_accum_ctrl: RTL
===================

# xpb_accum_ctrl

Sequencer for the XPB reduction lookup tables in the modular-squaring datapath. Captures a vector of NUM_DIGITS upper-product digits and issues one digit per cycle to the shared, registered XPB table bank. Accumulates the returned DATA_W-bit residues into a carry-free wide sum and pulses `done` when the sum is final. Sits between the squarer's partial-product split and the final reduction adder.

## Interface

Parameters:
- `DIGIT_W`, 5, bits per digit; the table address width.
- `NUM_DIGITS`, 8, digits per operation; one XPB table per digit position.
- `DATA_W`, 1024, table entry width.
- Derived localparams: `SEL_W = $clog2(NUM_DIGITS)`; `ACC_W = DATA_W + $clog2(NUM_DIGITS)`.

Ports:
- `clk` in 1: the single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: request a new operation; sampled only when idle.
- `digits_in` in NUM_DIGITS*DIGIT_W: digit i is bits [i*DIGIT_W +: DIGIT_W]; captured when `start` is accepted.
- `busy` out 1: operation in progress.
- `lut_req` out 1: `lut_sel`/`lut_addr` carry a real lookup this cycle.
- `lut_sel` out SEL_W: table index; equals the digit position.
- `lut_addr` out DIGIT_W: table address; forced to 0 when `lut_req`=0.
- `lut_data` in DATA_W: registered table output; valid one cycle after the address.
- `acc_out` out ACC_W: accumulated sum.
- `done` out 1: one-cycle pulse; `acc_out` is final.

## Operation

- States: IDLE, ISSUE, DRAIN, DONE.
- Reset values: state IDLE; `busy`, `done`, `lut_req`, `lut_sel`, `lut_addr`, `acc_out` all 0; in-flight valid bit 0.
- IDLE/DONE with `start`=1: capture digits, clear accumulator to 0, set digit index to 0, go to ISSUE.
- `start` in ISSUE or DRAIN is ignored. There is no queueing.
- ISSUE: each cycle drive `lut_req`=1, `lut_sel`=index, `lut_addr`=digit[index], then increment the index.
  - After issuing index NUM_DIGITS-1, go to DRAIN.
- One-bit valid pipeline follows `lut_req` by one cycle. When it is set, `acc <= acc + zero_extend(lut_data)`.
- DRAIN: one cycle that absorbs the last return, then go to DONE.
- DONE: `done`=1 for one cycle. Return to IDLE unless `start` is accepted that same cycle.
- `acc_out` holds its final value until the next accepted `start` clears it.
- Arithmetic: unsigned. ACC_W guarantees no overflow: NUM_DIGITS*(2^DATA_W-1) < 2^ACC_W.
- `rst_n` low mid-operation: immediate abort. All outputs go to reset values, and any in-flight return is discarded.

## Timing

- Count cycles from the edge that accepts `start` (cycle 0).
- Addresses are driven in cycles 1..NUM_DIGITS.
- `busy`=1 in cycles 1..NUM_DIGITS+1.
- `done`=1 in cycle NUM_DIGITS+2.
- A new `start` in the `done` cycle begins the next operation with no bubble.
- Table read latency is exactly 1 cycle and is not configurable.

## Configuration

- `XPB_ZERO_SKIP_EN` defined:
  - ISSUE issues only nonzero digits, lowest position first, one per cycle. This is legal because entry 0 of every table is 0.
  - With M nonzero digits, ISSUE lasts max(M,1) cycles. If M=0, ISSUE spends one cycle with `lut_req`=0.
  - `done` arrives at cycle max(M,1)+2.
- Undefined: fixed latency as specified above. All digits are issued, including zeros.

## Structure

- Package `xpb_pkg`: `DIGIT_W` default constant, state enum `xpb_ctrl_state_t`.
- Sub-module `xpb_digit_picker`, instantiated only under `XPB_ZERO_SKIP_EN`.
  - Function: find-first-set over the pending nonzero mask.
  - Outputs: index, found flag, and the mask with that bit cleared.

## Test plan

Bench model table: registered, returns `(lut_sel<<8) | lut_addr`.

- Digits i+1 for i=0..7, start -> `done` in cycle 10, `acc_out`=0x1C24, `busy` high cycles 1..9.
- All digits 0 -> `acc_out`=0. `done` in cycle 10 without the macro; in cycle 3 with `XPB_ZERO_SKIP_EN`, with `lut_req` low throughout.
- Model returns all-ones for every access, digits all 31 -> `acc_out`=8*(2^1024-1) (top bits 0b111, low byte 0xF8), no truncation.
- `start` re-asserted in cycles 2..8 -> ignored; a single `done` in cycle 10 with the correct sum.
- `rst_n` pulsed low in cycle 4 -> all outputs 0 immediately, no `done`. A following start gives the correct result at +10 cycles.
- Second start in the `done` cycle with digits {0,0,0,5,0,0,0,0} -> second `done` 10 cycles later, `acc_out`=0x305. With the macro, `done` comes 3 cycles later.

Source files
------------

// File: rtl/xpb_pkg.sv
// Shared defaults and controller state type for the XPB accumulation sequencer.
package xpb_pkg;

  localparam int unsigned DIGIT_W_DFLT    = 5;
  localparam int unsigned NUM_DIGITS_DFLT = 8;
  localparam int unsigned DATA_W_DFLT     = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } xpb_ctrl_state_t;

endpackage

// File: rtl/xpb_accum_ctrl_if.sv
// Operand/result handshake plus XPB table-bank port of the accumulation sequencer.
interface xpb_accum_ctrl_if
  import xpb_pkg::*;
#(
  parameter int unsigned DIGIT_W    = DIGIT_W_DFLT,
  parameter int unsigned NUM_DIGITS = NUM_DIGITS_DFLT,
  parameter int unsigned DATA_W     = DATA_W_DFLT
);
  localparam int unsigned SEL_W = $clog2(NUM_DIGITS);
  localparam int unsigned ACC_W = DATA_W + $clog2(NUM_DIGITS);

  logic                          start;
  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in;
  logic                          busy;
  logic                          lut_req;
  logic [SEL_W-1:0]              lut_sel;
  logic [DIGIT_W-1:0]            lut_addr;
  logic [DATA_W-1:0]             lut_data;
  logic [ACC_W-1:0]              acc_out;
  logic                          done;

  // master: the sequencer itself; slave: squarer front end plus table bank
  modport master (
    input  start, digits_in, lut_data,
    output busy, lut_req, lut_sel, lut_addr, acc_out, done
  );

  modport slave (
    output start, digits_in, lut_data,
    input  busy, lut_req, lut_sel, lut_addr, acc_out, done
  );

endinterface

// File: rtl/xpb_digit_picker.sv
// Find-first-set over the pending nonzero-digit mask; returns the lowest index and the mask without it.
module xpb_digit_picker #(
  parameter int unsigned NUM_DIGITS = 8,
  localparam int unsigned SEL_W     = $clog2(NUM_DIGITS)
) (
  input  logic [NUM_DIGITS-1:0] mask,
  output logic [SEL_W-1:0]      idx,
  output logic                  found,
  output logic [NUM_DIGITS-1:0] rest
);

  always_comb begin
    idx   = '0;
    found = |mask;
    rest  = mask;
    // descending scan so the lowest set bit wins
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      if (mask[i]) idx = SEL_W'(i);
    end
    rest[idx] = 1'b0;
  end

endmodule

// File: rtl/xpb_accum_ctrl.sv
// XPB lookup sequencer: issues one digit per cycle to the registered table bank and sums the residues.
// Optional XPB_ZERO_SKIP_EN issues only nonzero digits (entry 0 of every table is 0).
module xpb_accum_ctrl
  import xpb_pkg::*;
#(
  parameter int unsigned DIGIT_W    = DIGIT_W_DFLT,
  parameter int unsigned NUM_DIGITS = NUM_DIGITS_DFLT,
  parameter int unsigned DATA_W     = DATA_W_DFLT
) (
  input logic               clk,
  input logic               rst_n,
  xpb_accum_ctrl_if.master  bus
);

  localparam int unsigned SEL_W = $clog2(NUM_DIGITS);
  localparam int unsigned ACC_W = DATA_W + $clog2(NUM_DIGITS);
  localparam int unsigned VEC_W = NUM_DIGITS * DIGIT_W;

  xpb_ctrl_state_t    state_q;
  logic               busy_q;
  logic               done_q;
  logic               lut_req_q;
  logic               vld_q;
  logic [SEL_W-1:0]   lut_sel_q;
  logic [DIGIT_W-1:0] lut_addr_q;
  logic [ACC_W-1:0]   acc_q;
  logic [VEC_W-1:0]   digits_q;

  logic               accept_c;
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic [DIGIT_W-1:0] pick_addr;
  logic [VEC_W-1:0]   src_c;

  assign accept_c = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
  // the first lookup is launched on the accepting edge, straight from the input vector
  assign src_c    = accept_c ? bus.digits_in : digits_q;

  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (pick_idx == SEL_W'(i)) pick_addr = src_c[i*DIGIT_W +: DIGIT_W];
    end
  end

`ifdef XPB_ZERO_SKIP_EN
  logic [NUM_DIGITS-1:0] pend_q;
  logic [NUM_DIGITS-1:0] pick_mask;
  logic [NUM_DIGITS-1:0] pick_rest;

  always_comb begin
    pick_mask = pend_q;
    if (accept_c) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        pick_mask[i] = |bus.digits_in[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  xpb_digit_picker #(.NUM_DIGITS(NUM_DIGITS)) u_picker (
    .mask  (pick_mask),
    .idx   (pick_idx),
    .found (pick_found),
    .rest  (pick_rest)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else if (accept_c || (state_q == ST_ISSUE && pick_found)) begin
      pend_q <= pick_rest;
    end
  end
`else
  // the currently issued position lives in lut_sel_q
  always_comb begin
    pick_found = accept_c || (lut_sel_q != SEL_W'(NUM_DIGITS - 1));
    pick_idx   = accept_c ? '0 : lut_sel_q + SEL_W'(1);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      lut_req_q  <= 1'b0;
      lut_sel_q  <= '0;
      lut_addr_q <= '0;
      acc_q      <= '0;
      vld_q      <= 1'b0;
      digits_q   <= '0;
    end else begin
      vld_q  <= lut_req_q;
      done_q <= 1'b0;
      if (vld_q) acc_q <= acc_q + ACC_W'(bus.lut_data);
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept_c) begin
            state_q    <= ST_ISSUE;
            busy_q     <= 1'b1;
            acc_q      <= '0;
            digits_q   <= bus.digits_in;
            lut_req_q  <= pick_found;
            lut_sel_q  <= pick_found ? pick_idx : '0;
            lut_addr_q <= pick_found ? pick_addr : '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (pick_found) begin
            lut_req_q  <= 1'b1;
            lut_sel_q  <= pick_idx;
            lut_addr_q <= pick_addr;
          end else begin
            state_q    <= ST_DRAIN;
            lut_req_q  <= 1'b0;
            lut_addr_q <= '0;
          end
        end
        ST_DRAIN: begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.lut_req  = lut_req_q;
  assign bus.lut_sel  = lut_sel_q;
  assign bus.lut_addr = lut_addr_q;
  assign bus.acc_out  = acc_q;

endmodule
